// File: rtl/rc4_sched_pkg.sv
// Shared types and constants for the RC4 phase scheduler: FSM states, memory-port phases, status LED codes.
package rc4_sched_pkg;

    localparam int unsigned KEY_W_DEF  = 24;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT_RUN = 3'd1,
        ST_SHUF_RUN = 3'd2,
        ST_DEC_RUN  = 3'd3,
        ST_NEXT_KEY = 3'd4,
        ST_FOUND    = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_SHUF = 2'd2,
        PH_DEC  = 2'd3
    } phase_t;

    localparam logic [2:0] LIGHT_IDLE  = 3'b100;
    localparam logic [2:0] LIGHT_INIT  = 3'b001;
    localparam logic [2:0] LIGHT_SHUF  = 3'b010;
    localparam logic [2:0] LIGHT_DEC   = 3'b011;
    localparam logic [2:0] LIGHT_FOUND = 3'b101;
    localparam logic [2:0] LIGHT_FAIL  = 3'b110;

    // Which engine owns the S-memory port in a given state.
    function automatic phase_t state_phase(input state_t s);
        case (s)
            ST_INIT_RUN: return PH_INIT;
            ST_SHUF_RUN: return PH_SHUF;
            ST_DEC_RUN:  return PH_DEC;
            default:     return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational 3-to-1 S-memory port mux; the port is idle (all zero) when no engine owns it.
module rc4_mem_mux
    import rc4_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  phase_t             phase,
    input  logic [ADDR_W-1:0]  init_addr,
    input  logic [DATA_W-1:0]  init_wdata,
    input  logic               init_wren,
    input  logic [ADDR_W-1:0]  shuf_addr,
    input  logic [DATA_W-1:0]  shuf_wdata,
    input  logic               shuf_wren,
    input  logic [ADDR_W-1:0]  dec_addr,
    input  logic [DATA_W-1:0]  dec_wdata,
    input  logic               dec_wren,
    output logic [ADDR_W-1:0]  mem_addr_c,
    output logic [DATA_W-1:0]  mem_wdata_c,
    output logic               mem_wren_c
);

    always_comb begin
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_wren_c  = 1'b0;
        case (phase)
            PH_INIT: begin
                mem_addr_c  = init_addr;
                mem_wdata_c = init_wdata;
                mem_wren_c  = init_wren;
            end
            PH_SHUF: begin
                mem_addr_c  = shuf_addr;
                mem_wdata_c = shuf_wdata;
                mem_wren_c  = shuf_wren;
            end
            PH_DEC: begin
                mem_addr_c  = dec_addr;
                mem_wdata_c = dec_wdata;
                mem_wren_c  = dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_phase_scheduler.sv
// Sequences the RC4 init / shuffle / decrypt engines and owns the shared S-memory port.
// RC4_KEY_SEARCH_EN: sweep keys 0..KEY_MAX until decrypt reports valid text (KEY_MAX exists only then).
module rc4_phase_scheduler
    import rc4_sched_pkg::*;
#(
    parameter int unsigned KEY_W  = KEY_W_DEF,
`ifdef RC4_KEY_SEARCH_EN
    parameter logic [KEY_W-1:0] KEY_MAX = KEY_W'(24'h3FFFFF),
`endif
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clok,
    input  logic              rst,
    input  logic              go,
    input  logic [KEY_W-1:0]  key_in,
    output logic              init_start,
    output logic              shuf_start,
    output logic              dec_start,
    input  logic              init_done,
    input  logic              shuf_done,
    input  logic              dec_done,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] shuf_addr,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] init_wdata,
    input  logic [DATA_W-1:0] shuf_wdata,
    input  logic [DATA_W-1:0] dec_wdata,
    input  logic              init_wren,
    input  logic              shuf_wren,
    input  logic              dec_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              found,
    output logic              fail,
    output logic [2:0]        light
);

    state_t state;
    phase_t phase;

    assign phase = state_phase(state);

    rc4_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .phase       (phase),
        .init_addr   (init_addr),
        .init_wdata  (init_wdata),
        .init_wren   (init_wren),
        .shuf_addr   (shuf_addr),
        .shuf_wdata  (shuf_wdata),
        .shuf_wren   (shuf_wren),
        .dec_addr    (dec_addr),
        .dec_wdata   (dec_wdata),
        .dec_wren    (dec_wren),
        .mem_addr_c  (mem_addr),
        .mem_wdata_c (mem_wdata),
        .mem_wren_c  (mem_wren)
    );

    // Phase sequencer; every status output is registered alongside the state.
    always_ff @(posedge clok) begin
        if (!rst) begin
            state      <= ST_IDLE;
            init_start <= 1'b0;
            shuf_start <= 1'b0;
            dec_start  <= 1'b0;
            key        <= '0;
            busy       <= 1'b0;
            found      <= 1'b0;
            fail       <= 1'b0;
            light      <= LIGHT_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (go) begin
                        state      <= ST_INIT_RUN;
                        init_start <= 1'b1;
`ifdef RC4_KEY_SEARCH_EN
                        key        <= '0;
`else
                        key        <= key_in;
`endif
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        fail       <= 1'b0;
                        light      <= LIGHT_INIT;
                    end
                end
                ST_INIT_RUN: begin
                    if (init_done) begin
                        state      <= ST_SHUF_RUN;
                        init_start <= 1'b0;
                        shuf_start <= 1'b1;
                        light      <= LIGHT_SHUF;
                    end
                end
                ST_SHUF_RUN: begin
                    if (shuf_done) begin
                        state      <= ST_DEC_RUN;
                        shuf_start <= 1'b0;
                        dec_start  <= 1'b1;
                        light      <= LIGHT_DEC;
                    end
                end
                ST_DEC_RUN: begin
                    if (dec_done) begin
                        dec_start <= 1'b0;
                        if (dec_valid) begin
                            state <= ST_FOUND;
                            busy  <= 1'b0;
                            found <= 1'b1;
                            light <= LIGHT_FOUND;
                        end else begin
`ifdef RC4_KEY_SEARCH_EN
                            state <= ST_NEXT_KEY;
`else
                            state <= ST_FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                            light <= LIGHT_FAIL;
`endif
                        end
                    end
                end
`ifdef RC4_KEY_SEARCH_EN
                // Max-key test comes first so the key never wraps.
                ST_NEXT_KEY: begin
                    if (key == KEY_MAX) begin
                        state <= ST_FAIL;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                        light <= LIGHT_FAIL;
                    end else begin
                        state      <= ST_INIT_RUN;
                        key        <= key + KEY_W'(1);
                        init_start <= 1'b1;
                        light      <= LIGHT_INIT;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    init_start <= 1'b0;
                    shuf_start <= 1'b0;
                    dec_start  <= 1'b0;
                    busy       <= 1'b0;
                    found      <= 1'b0;
                    fail       <= 1'b0;
                    light      <= LIGHT_IDLE;
                end
            endcase
        end
    end

endmodule
